// File: rtl/core_mailbox_if.sv
// Inter-core mailbox bus: four byte channels from a sender core to a receiver core.
// master: the core side (drives tx data/strobes, rx read-acks and error clears).
// slave:  the mailbox side (returns head data, valid/full status and sticky error flags).
interface core_mailbox_if;
   logic [7:0] tx_data_0;
   logic [7:0] tx_data_1;
   logic [7:0] tx_data_2;
   logic [7:0] tx_data_3;
   logic [3:0] tx_strobe;    // active-low write strobes
   logic [7:0] rx_data_0;
   logic [7:0] rx_data_1;
   logic [7:0] rx_data_2;
   logic [7:0] rx_data_3;
   logic [3:0] rx_strobe;    // active-low read acknowledges
   logic [3:0] rx_valid;
   logic [3:0] tx_full;
   logic [3:0] overflow;
   logic [3:0] underflow;
   logic [3:0] err_clr;

   modport master (
      output tx_data_0, tx_data_1, tx_data_2, tx_data_3, tx_strobe, rx_strobe, err_clr,
      input  rx_data_0, rx_data_1, rx_data_2, rx_data_3, rx_valid, tx_full, overflow, underflow
   );

   modport slave (
      input  tx_data_0, tx_data_1, tx_data_2, tx_data_3, tx_strobe, rx_strobe, err_clr,
      output rx_data_0, rx_data_1, rx_data_2, rx_data_3, rx_valid, tx_full, overflow, underflow
   );
endinterface

// File: rtl/core_mailbox.sv
// Purpose: four independent DEPTH x 8 byte FIFOs carrying OUTPUT Rn -> INPUT Rn between two cores.
// Latency: a push at edge N is visible on rx_data/rx_valid right after edge N; pops likewise.
// Backpressure: none on the strobes; push while full is dropped, pop while empty ignored (sticky flags).
// Ports: clk, reset (async, active-high), bus (core_mailbox_if.slave: tx_data_0..3, tx_strobe,
//        rx_data_0..3, rx_strobe, rx_valid, tx_full, overflow, underflow, err_clr).
// Build option: define MAILBOX_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module core_mailbox #(
   parameter int         DEPTH     = 4,
   parameter logic [7:0] EMPTY_VAL = 8'h00
) (
   input logic           clk,
   input logic           reset,
   core_mailbox_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [7:0]    mem_q  [4][DEPTH];
   logic [7:0]    mem_d  [4][DEPTH];
   logic [AW-1:0] wptr_q [4];
   logic [AW-1:0] wptr_d [4];
   logic [AW-1:0] rptr_q [4];
   logic [AW-1:0] rptr_d [4];
   logic [AW:0]   cnt_q  [4];
   logic [AW:0]   cnt_d  [4];
   logic [3:0]    tx_prev_q, tx_prev_d;
   logic [3:0]    rx_prev_q, rx_prev_d;
   // Low for the first edge after reset release, so a strobe that is already
   // low when reset drops is absorbed into tx_prev/rx_prev without an event.
   logic          arm_q, arm_d;

   logic [7:0]    tx_dat [4];
   logic [7:0]    rx_dat [4];
   logic [3:0]    push_evt, pop_evt, empty, full, do_push, do_pop;

   assign tx_dat[0] = bus.tx_data_0;
   assign tx_dat[1] = bus.tx_data_1;
   assign tx_dat[2] = bus.tx_data_2;
   assign tx_dat[3] = bus.tx_data_3;

   always_comb begin
      push_evt = '0;
      pop_evt  = '0;
      empty    = '0;
      full     = '0;
      do_push  = '0;
      do_pop   = '0;
      for (int i = 0; i < 4; i++) begin
         push_evt[i] = arm_q & ~bus.tx_strobe[i] & tx_prev_q[i];
         pop_evt[i]  = arm_q & ~bus.rx_strobe[i] & rx_prev_q[i];
         empty[i]    = (cnt_q[i] == '0);
         full[i]     = (cnt_q[i] == CNT_FULL);
         do_pop[i]   = pop_evt[i] & ~empty[i];
         // A simultaneous pop frees the slot, so a push into a full channel still lands.
         do_push[i]  = push_evt[i] & (~full[i] | do_pop[i]);
         rx_dat[i]   = empty[i] ? EMPTY_VAL : mem_q[i][rptr_q[i]];
      end
   end

   always_comb begin
      mem_d     = mem_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      tx_prev_d = bus.tx_strobe;
      rx_prev_d = bus.rx_strobe;
      arm_d     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (do_push[i]) begin
            mem_d[i][wptr_q[i]] = tx_dat[i];
            wptr_d[i]           = wptr_q[i] + PTR_ONE;
         end
         if (do_pop[i]) begin
            rptr_d[i] = rptr_q[i] + PTR_ONE;
         end
         case ({do_push[i], do_pop[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
            2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               mem_q[i][j] <= '0;
            end
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         tx_prev_q <= 4'b1111;
         rx_prev_q <= 4'b1111;
         arm_q     <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         tx_prev_q <= tx_prev_d;
         rx_prev_q <= rx_prev_d;
         arm_q     <= arm_d;
      end
   end

   assign bus.rx_data_0 = rx_dat[0];
   assign bus.rx_data_1 = rx_dat[1];
   assign bus.rx_data_2 = rx_dat[2];
   assign bus.rx_data_3 = rx_dat[3];
   assign bus.rx_valid  = ~empty;
   assign bus.tx_full   = full;

`ifdef MAILBOX_ERR_FLAGS_EN
   logic [3:0] ovf_q, ovf_d, udf_q, udf_d, ovf_evt, udf_evt;

   always_comb begin
      ovf_evt = push_evt & ~do_push;
      udf_evt = pop_evt & empty;
      // A new error in the same cycle as err_clr keeps the flag set.
      ovf_d   = ovf_evt | (ovf_q & ~bus.err_clr);
      udf_d   = udf_evt | (udf_q & ~bus.err_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= '0;
         udf_q <= '0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = ^bus.err_clr;
   assign bus.overflow   = 4'b0000;
   assign bus.underflow  = 4'b0000;
`endif
endmodule

// File: tb/tb_core_mailbox.sv
// Bench for core_mailbox: directed test-plan steps plus a random phase, all checked
// against a queue-per-channel reference model built from the channel rules.
module tb_core_mailbox;
   localparam int DEPTH = 4;
`ifdef MAILBOX_ERR_FLAGS_EN
   localparam logic EF = 1'b1;
`else
   localparam logic EF = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   core_mailbox_if bus ();

   core_mailbox #(.DEPTH(DEPTH), .EMPTY_VAL(8'h00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   // Reference model
   logic [7:0] mq [4][$];
   logic [3:0] tx_prev_m, rx_prev_m, ovf_m, udf_m;
   logic       armed_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [7:0] rxd(input int ch);
      case (ch)
         0: return bus.rx_data_0;
         1: return bus.rx_data_1;
         2: return bus.rx_data_2;
         default: return bus.rx_data_3;
      endcase
   endfunction

   task automatic set_tx(input int ch, input logic [7:0] d);
      case (ch)
         0: bus.tx_data_0 = d;
         1: bus.tx_data_1 = d;
         2: bus.tx_data_2 = d;
         default: bus.tx_data_3 = d;
      endcase
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mq[i].delete();
      tx_prev_m = 4'b1111;
      rx_prev_m = 4'b1111;
      ovf_m     = 4'b0000;
      udf_m     = 4'b0000;
      armed_m   = 1'b0;
   endtask

   task automatic check_all();
      logic [3:0]  ev, ef;
      logic [31:0] ed, od;
      for (int i = 0; i < 4; i++) begin
         ev[i] = (mq[i].size() != 0);
         ef[i] = (mq[i].size() == DEPTH);
         ed[i*8 +: 8] = ev[i] ? mq[i][0] : 8'h00;
         od[i*8 +: 8] = rxd(i);
      end
      chk("rx_valid",  {28'd0, bus.rx_valid},  {28'd0, ev});
      chk("tx_full",   {28'd0, bus.tx_full},   {28'd0, ef});
      chk("rx_data",   od, ed);
      chk("overflow",  {28'd0, bus.overflow},  {28'd0, ovf_m & {4{EF}}});
      chk("underflow", {28'd0, bus.underflow}, {28'd0, udf_m & {4{EF}}});
   endtask

   // One clock: derive events from the inputs applied before the edge,
   // update the queues, then check all outputs just after the edge.
   task automatic cycle();
      logic [3:0] push, pop, clr;
      logic [7:0] dat [4];
      push   = armed_m ? (~bus.tx_strobe & tx_prev_m) : 4'b0000;
      pop    = armed_m ? (~bus.rx_strobe & rx_prev_m) : 4'b0000;
      clr    = bus.err_clr;
      dat[0] = bus.tx_data_0;
      dat[1] = bus.tx_data_1;
      dat[2] = bus.tx_data_2;
      dat[3] = bus.tx_data_3;
      tx_prev_m = bus.tx_strobe;
      rx_prev_m = bus.rx_strobe;
      armed_m   = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         logic oe, ue;
         oe = 1'b0;
         ue = 1'b0;
         if (pop[i]) begin
            if (mq[i].size() > 0) void'(mq[i].pop_front());
            else ue = 1'b1;
         end
         if (push[i]) begin
            if (mq[i].size() < DEPTH) mq[i].push_back(dat[i]);
            else oe = 1'b1;
         end
         ovf_m[i] = oe | (ovf_m[i] & ~clr[i]);
         udf_m[i] = ue | (udf_m[i] & ~clr[i]);
      end
      #1;
      check_all();
   endtask

   task automatic push(input int ch, input logic [7:0] d);
      set_tx(ch, d);
      bus.tx_strobe[ch] = 1'b0;
      cycle();
      bus.tx_strobe[ch] = 1'b1;
      cycle();
   endtask

   task automatic pop(input int ch);
      bus.rx_strobe[ch] = 1'b0;
      cycle();
      bus.rx_strobe[ch] = 1'b1;
      cycle();
   endtask

   initial begin
      bus.tx_data_0 = 8'h00;
      bus.tx_data_1 = 8'h00;
      bus.tx_data_2 = 8'h00;
      bus.tx_data_3 = 8'h00;
      bus.tx_strobe = 4'b1111;
      bus.rx_strobe = 4'b1111;
      bus.err_clr   = 4'b0000;
      model_reset();

      // Reset state, with a strobe already low when reset releases.
      reset = 1'b1;
      bus.tx_strobe[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("reset_rx_data", {bus.rx_data_3, bus.rx_data_2, bus.rx_data_1, bus.rx_data_0}, 32'h0);
      reset = 1'b0;
      cycle();
      cycle();
      chk("low_at_release_no_push", {31'd0, bus.rx_valid[0]}, 32'd0);
      bus.tx_strobe[0] = 1'b1;
      cycle();

      // Ch2 ordering and drain to EMPTY_VAL.
      push(2, 8'h11);
      push(2, 8'h22);
      push(2, 8'h33);
      chk("ch2_head0", {24'd0, rxd(2)}, 32'h11);
      pop(2);
      chk("ch2_head1", {24'd0, rxd(2)}, 32'h22);
      pop(2);
      chk("ch2_head2", {24'd0, rxd(2)}, 32'h33);
      pop(2);
      chk("ch2_empty_val", {24'd0, rxd(2)}, 32'h00);
      chk("ch2_valid_drop", {31'd0, bus.rx_valid[2]}, 32'd0);

      // Ch0 fill past DEPTH, drain, then clear overflow.
      for (int v = 1; v <= 5; v++) begin
         push(0, 8'(v));
         if (v == 4) chk("ch0_full_after_4", {31'd0, bus.tx_full[0]}, 32'd1);
      end
      chk("ch0_overflow_after_5", {31'd0, bus.overflow[0]}, {31'd0, EF});
      for (int v = 1; v <= 4; v++) begin
         chk("ch0_pop_order", {24'd0, rxd(0)}, 32'(v));
         pop(0);
      end
      bus.err_clr[0] = 1'b1;
      cycle();
      bus.err_clr[0] = 1'b0;
      cycle();
      chk("ch0_overflow_cleared", {31'd0, bus.overflow[0]}, 32'd0);

      // Ch1 full: simultaneous push and pop.
      for (int v = 0; v < 4; v++) push(1, 8'hB0 + 8'(v));
      set_tx(1, 8'hAA);
      bus.tx_strobe[1] = 1'b0;
      bus.rx_strobe[1] = 1'b0;
      cycle();
      bus.tx_strobe[1] = 1'b1;
      bus.rx_strobe[1] = 1'b1;
      cycle();
      chk("ch1_full_pushpop_full", {31'd0, bus.tx_full[1]}, 32'd1);
      chk("ch1_full_pushpop_noovf", {31'd0, bus.overflow[1]}, 32'd0);
      chk("ch1_head_advanced", {24'd0, rxd(1)}, 32'hB1);
      for (int v = 0; v < 3; v++) pop(1);
      chk("ch1_aa_last", {24'd0, rxd(1)}, 32'hAA);
      pop(1);

      // Ch1 empty: simultaneous push and pop.
      set_tx(1, 8'h5A);
      bus.tx_strobe[1] = 1'b0;
      bus.rx_strobe[1] = 1'b0;
      cycle();
      chk("ch1_empty_underflow", {31'd0, bus.underflow[1]}, {31'd0, EF});
      chk("ch1_empty_data", {24'd0, rxd(1)}, 32'h5A);
      bus.tx_strobe[1] = 1'b1;
      bus.rx_strobe[1] = 1'b1;
      cycle();
      pop(1);
      bus.err_clr = 4'b1111;
      cycle();
      bus.err_clr = 4'b0000;

      // Held strobe gives one entry; concurrent pushes on ch0 and ch3.
      set_tx(3, 8'h7F);
      bus.tx_strobe[3] = 1'b0;
      repeat (5) cycle();
      bus.tx_strobe[3] = 1'b1;
      cycle();
      pop(3);
      chk("ch3_single_entry", {31'd0, bus.rx_valid[3]}, 32'd0);
      set_tx(0, 8'hC0);
      set_tx(3, 8'hC3);
      bus.tx_strobe = 4'b0110;
      cycle();
      bus.tx_strobe = 4'b1111;
      cycle();
      chk("concurrent_valid", {28'd0, bus.rx_valid}, 32'h9);

      // Async reset mid-stream with entries queued in ch0.
      push(0, 8'hD1);
      reset = 1'b1;
      #1;
      chk("async_reset_valid0", {31'd0, bus.rx_valid[0]}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle();

      // Core-to-core transfer of 42 on port 1 with EXECUTE/WRITE_BACK timing.
      set_tx(1, 8'd42);
      cycle();
      bus.tx_strobe[1] = 1'b0;
      cycle();
      bus.tx_strobe[1] = 1'b1;
      begin
         int n;
         n = 0;
         while (!bus.rx_valid[1] && n < 20) begin
            cycle();
            n++;
         end
         chk("core_wait_rx_valid", {31'd0, bus.rx_valid[1]}, 32'd1);
      end
      chk("core_receiver_r1", {24'd0, rxd(1)}, 32'd42);
      cycle();
      pop(1);
      chk("core_rx_valid_after", {31'd0, bus.rx_valid[1]}, 32'd0);

      // Random traffic on all channels.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 4; i++) begin
            bus.tx_strobe[i] = ($urandom_range(0, 9) >= 4);
            bus.rx_strobe[i] = ($urandom_range(0, 9) >= 4);
            bus.err_clr[i]   = ($urandom_range(0, 15) == 0);
            set_tx(i, 8'($urandom));
         end
         cycle();
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
